// File: rtl/uarch_pkg.sv
// uarch_pkg: shared micro-architecture widths and types for the fetch/decode path,
// including the instruction queue entry format and the canonical NOP.
package uarch_pkg;
  localparam int CPU_ADDR_BITS = 32;
  localparam int CPU_INST_BITS = 32;
  localparam int PIPE_WIDTH = 2;
  localparam int IBUF_DEPTH = 8;
  localparam logic [CPU_INST_BITS-1:0] INST_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [CPU_ADDR_BITS-1:0] pc;
    logic [CPU_INST_BITS-1:0] inst;
  } ibuf_entry_t;
endpackage

// File: rtl/inst_queue.sv
// inst_queue: circular fetch-to-decode queue issuing aligned instruction pairs.
// Define IBUF_DRAIN_EN to issue a lone instruction padded with a NOP instead of waiting for a partner.
module inst_queue
  import uarch_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      flush,
  input  logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0]  fetch_pcs,
  input  logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0]  fetch_insts,
  input  logic [PIPE_WIDTH-1:0]                     fetch_slot_val,
  output logic                                      ibuf_rdy,
  input  logic                                      decode_rdy,
  output logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0]  inst_pcs,
  output logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0]  insts,
  output logic                                      fetch_val,
  output logic [$clog2(DEPTH):0]                    occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  ibuf_entry_t mem_q [DEPTH];
  ibuf_entry_t e0, e1;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, count, push_n, pop_n;
  logic [AW-1:0] wr0, wr1, rd1;
  logic push, pop, lone;
  // Pointers carry a wrap bit, so full-width subtraction yields 0..DEPTH.
  assign count = tail_q - head_q;
  assign occupancy = count;
  assign ibuf_rdy = count <= PW'(DEPTH - 2);
  assign push = ibuf_rdy && |fetch_slot_val;
  assign push_n = PW'(fetch_slot_val[0]) + PW'(fetch_slot_val[1]);
`ifdef IBUF_DRAIN_EN
  assign lone = count == PW'(1);
`else
  assign lone = 1'b0;
`endif
  assign fetch_val = count >= PW'(2) || lone;
  assign pop = fetch_val && decode_rdy;
  assign pop_n = lone ? PW'(1) : PW'(2);
  assign head_d = flush ? '0 : pop ? head_q + pop_n : head_q;
  assign tail_d = flush ? '0 : push ? tail_q + push_n : tail_q;
  // Slot 1 lands right after slot 0 only when slot 0 was valid, compacting sparse fetches.
  assign wr0 = tail_q[AW-1:0];
  assign wr1 = tail_q[AW-1:0] + AW'(fetch_slot_val[0]);
  assign rd1 = head_q[AW-1:0] + AW'(1);
  always_comb begin
    e0 = mem_q[head_q[AW-1:0]];
    e1 = mem_q[rd1];
    if (lone) begin
      e1.pc = e0.pc + CPU_ADDR_BITS'(4);
      e1.inst = INST_NOP;
    end
    inst_pcs[0] = fetch_val ? e0.pc : '0;
    inst_pcs[1] = fetch_val ? e1.pc : '0;
    insts[0] = fetch_val ? e0.inst : '0;
    insts[1] = fetch_val ? e1.inst : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      if (fetch_slot_val[0]) mem_q[wr0] <= '{pc: fetch_pcs[0], inst: fetch_insts[0]};
      if (fetch_slot_val[1]) mem_q[wr1] <= '{pc: fetch_pcs[1], inst: fetch_insts[1]};
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: table-driven and scoreboard checks of inst_queue pair scheduling,
// backpressure, compaction, wrap, flush and async reset.
module tb_inst_queue;
  import uarch_pkg::*;
  logic clk = 1'b0;
  logic rst_n, flush, decode_rdy, ibuf_rdy, fetch_val;
  logic [1:0][31:0] fetch_pcs, fetch_insts, inst_pcs, insts;
  logic [1:0] fetch_slot_val;
  logic [3:0] occupancy;
  int checks = 0;
  int errors = 0;
`ifdef IBUF_DRAIN_EN
  localparam bit DRAIN = 1'b1;
`else
  localparam bit DRAIN = 1'b0;
`endif
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  typedef struct {
    logic [1:0] sv;
    logic [31:0] p0, p1;
    logic dr;
    int occ;
    logic fv, rdy;
  } vec_t;
  ent_t sb[$];
  vec_t vecs[11];

  inst_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .fetch_pcs(fetch_pcs),
    .fetch_insts(fetch_insts), .fetch_slot_val(fetch_slot_val), .ibuf_rdy(ibuf_rdy),
    .decode_rdy(decode_rdy), .inst_pcs(inst_pcs), .insts(insts),
    .fetch_val(fetch_val), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] sv, input logic [31:0] p0, input logic [31:0] p1,
                       input logic dr, input logic fl);
    fetch_slot_val = sv;
    fetch_pcs[0] = p0;
    fetch_pcs[1] = p1;
    fetch_insts[0] = inst_of(p0);
    fetch_insts[1] = inst_of(p1);
    decode_rdy = dr;
    flush = fl;
  endtask

  // Compare DUT against the queue model, then apply this cycle's pop/push/flush to the model.
  task automatic sb_cycle();
    int sz = sb.size();
    logic mrdy, mfv;
    ent_t a, b;
    mrdy = (8 - sz) >= 2;
    mfv = DRAIN ? sz >= 1 : sz >= 2;
    chk("occupancy", 32'(occupancy), 32'(sz));
    chk("ibuf_rdy", 32'(ibuf_rdy), 32'(mrdy));
    chk("fetch_val", 32'(fetch_val), 32'(mfv));
    if (mfv) begin
      a = sb[0];
      if (sz >= 2) b = sb[1];
      else b = '{pc: a.pc + 32'd4, inst: INST_NOP};
    end else begin
      a = '{pc: 32'd0, inst: 32'd0};
      b = a;
    end
    chk("pc0", inst_pcs[0], a.pc);
    chk("pc1", inst_pcs[1], b.pc);
    chk("inst0", insts[0], a.inst);
    chk("inst1", insts[1], b.inst);
    if (flush) sb.delete();
    else begin
      if (mfv && decode_rdy) begin
        void'(sb.pop_front());
        if (sz >= 2) void'(sb.pop_front());
      end
      if (mrdy && fetch_slot_val[0]) sb.push_back('{pc: fetch_pcs[0], inst: fetch_insts[0]});
      if (mrdy && fetch_slot_val[1]) sb.push_back('{pc: fetch_pcs[1], inst: fetch_insts[1]});
    end
  endtask

  task automatic step(input logic [1:0] sv, input logic [31:0] p0, input logic [31:0] p1,
                      input logic dr, input logic fl);
    drive(sv, p0, p1, dr, fl);
    @(negedge clk);
    sb_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    #12;
    sb_cycle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Fill to full, attempt an overflow push, then drain in pairs.
    vecs[0]  = '{2'b11, 32'h00, 32'h04, 1'b0, 0, 1'b0, 1'b1};
    vecs[1]  = '{2'b11, 32'h08, 32'h0C, 1'b0, 2, 1'b1, 1'b1};
    vecs[2]  = '{2'b11, 32'h10, 32'h14, 1'b0, 4, 1'b1, 1'b1};
    vecs[3]  = '{2'b11, 32'h18, 32'h1C, 1'b0, 6, 1'b1, 1'b1};
    vecs[4]  = '{2'b11, 32'h20, 32'h24, 1'b0, 8, 1'b1, 1'b0};
    vecs[5]  = '{2'b00, 32'h00, 32'h00, 1'b0, 8, 1'b1, 1'b0};
    vecs[6]  = '{2'b00, 32'h00, 32'h00, 1'b1, 8, 1'b1, 1'b0};
    vecs[7]  = '{2'b00, 32'h00, 32'h00, 1'b1, 6, 1'b1, 1'b1};
    vecs[8]  = '{2'b00, 32'h00, 32'h00, 1'b1, 4, 1'b1, 1'b1};
    vecs[9]  = '{2'b00, 32'h00, 32'h00, 1'b1, 2, 1'b1, 1'b1};
    vecs[10] = '{2'b00, 32'h00, 32'h00, 1'b1, 0, 1'b0, 1'b1};
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].sv, vecs[i].p0, vecs[i].p1, vecs[i].dr, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(vecs[i].occ));
      chk($sformatf("vec%0d_fv", i), 32'(fetch_val), 32'(vecs[i].fv));
      chk($sformatf("vec%0d_rdy", i), 32'(ibuf_rdy), 32'(vecs[i].rdy));
      sb_cycle();
      @(posedge clk);
      #1;
    end
    // Sparse slots compact into one pair.
    step(2'b10, 32'hDEAD, 32'h104, 1'b0, 1'b0);
    step(2'b01, 32'h108, 32'hBEEF, 1'b0, 1'b0);
    drive(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("sparse_fv", 32'(fetch_val), 32'd1);
    chk("sparse_pc0", inst_pcs[0], 32'h104);
    chk("sparse_pc1", inst_pcs[1], 32'h108);
    sb_cycle();
    @(posedge clk);
    #1;
    // Steady state at six entries while the pointers wrap.
    for (int i = 0; i < 3; i++) step(2'b11, 32'h300 + 32'(i * 8), 32'h304 + 32'(i * 8), 1'b0, 1'b0);
    for (int i = 3; i < 13; i++) begin
      drive(2'b11, 32'h300 + 32'(i * 8), 32'h304 + 32'(i * 8), 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("wrap%0d_occ", i), 32'(occupancy), 32'd6);
      sb_cycle();
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) step(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
    // Flush at occupancy 5 wins over a simultaneous push and pop.
    step(2'b11, 32'h400, 32'h404, 1'b0, 1'b0);
    step(2'b11, 32'h408, 32'h40C, 1'b0, 1'b0);
    step(2'b01, 32'h0, 32'h410, 1'b0, 1'b0);
    chk("pre_flush_occ", 32'(occupancy), 32'd5);
    step(2'b11, 32'h500, 32'h504, 1'b1, 1'b1);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_fv", 32'(fetch_val), 32'd0);
    chk("flush_rdy", 32'(ibuf_rdy), 32'd1);
    // Asynchronous reset between clock edges.
    step(2'b11, 32'h600, 32'h604, 1'b0, 1'b0);
    drive(2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    #2;
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_fv", 32'(fetch_val), 32'd0);
    chk("arst_rdy", 32'(ibuf_rdy), 32'd1);
    chk("arst_pc0", inst_pcs[0], 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // A single leftover instruction: padded with a NOP or held back.
    step(2'b01, 32'h200, 32'h0, 1'b0, 1'b0);
    drive(2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lone_fv", 32'(fetch_val), 32'(DRAIN));
    chk("lone_pc1", inst_pcs[1], DRAIN ? 32'h204 : 32'h0);
    chk("lone_inst1", insts[1], DRAIN ? INST_NOP : 32'h0);
    sb_cycle();
    @(posedge clk);
    #1;
    step(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("lone_after_pop_occ", 32'(occupancy), DRAIN ? 32'd0 : 32'd1);
    step(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
